// File: rtl/rv32_mem_pkg.sv
// Shared constants for the RV32I MEM stage: funct3 access codes and FSM encoding.
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store replication, load extraction
// and extension, plus detection of misaligned or illegal funct3 encodings.
module lsu_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        err
);

    logic [31:0] shifted;
    logic        illegal;
    logic        misaligned;

    always_comb begin
        be         = 4'b0000;
        wdata      = store_data;
        misaligned = 1'b0;
        shifted    = rdata >> {offset, 3'b000};
        load_data  = 32'h0;

        // Size comes from funct3[1:0]; the sign bit funct3[2] only matters for loads.
        case (funct3[1:0])
            2'd0: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            2'd1: begin
                be         = 4'b0011 << offset;
                wdata      = {2{store_data[15:0]}};
                misaligned = offset[0];
            end
            2'd2: begin
                be         = 4'b1111;
                misaligned = |offset;
            end
            default: ;
        endcase

        illegal = (funct3[1:0] == 2'd3) || (funct3[2] && (is_store || funct3[1]));
        err     = illegal || misaligned;

        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            F3_W:    load_data = rdata;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I MEM stage: drives the req/ack data-memory port, stalls upstream while a
// transaction is outstanding and acts as the MEM/WB pipeline register.
module mem_access_unit
    import rv32_mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_in,
    input  logic        reg_we_in,
    input  logic [2:0]  wb_sel_in,
    input  logic        mem_request_type_in,
    input  logic        mem_request_write_in,
    input  logic [2:0]  funct3_in,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        stall_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] mem_data_out,
    output logic [4:0]  rd_out,
    output logic        reg_we_out,
    output logic [2:0]  wb_sel_out,
    output logic        fault_out
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t      state_reg, state_next;
    logic [31:0] addr_reg;
    logic [2:0]  funct3_reg;
    logic        we_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic [4:0]  rd_reg;
    logic [2:0]  wb_sel_reg;
    logic        reg_we_reg;
    logic [CW-1:0] cnt_reg;

    logic        waiting, start, bad, timeout_hit;
    logic [2:0]  al_funct3;
    logic [1:0]  al_offset;
    logic        al_store;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_load;
    logic        al_err;

    // While waiting, the aligner works on the latched access so extraction uses the right lane.
    assign al_funct3 = waiting ? funct3_reg     : funct3_in;
    assign al_offset = waiting ? addr_reg[1:0]  : addr_in[1:0];
    assign al_store  = waiting ? we_reg         : mem_request_write_in;

    lsu_align u_align (
        .funct3     (al_funct3),
        .offset     (al_offset),
        .is_store   (al_store),
        .store_data (store_data_in),
        .rdata      (dmem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .err        (al_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        waiting     = (state_reg == WAIT_ACK);
        timeout_hit = waiting && !dmem_ack && (TIMEOUT > 0) && (cnt_reg == CNT_LAST);
        start       = !waiting && mem_request_type_in && !al_err;
        bad         = !waiting && mem_request_type_in && al_err;
        state_next  = state_reg;
        case (state_reg)
            IDLE:     if (start) state_next = WAIT_ACK;
            WAIT_ACK: if (dmem_ack || timeout_hit) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        stall_out  = !rst && (waiting ? !(dmem_ack || timeout_hit) : start);
        dmem_req   = waiting;
        dmem_we    = waiting && we_reg;
        dmem_addr  = waiting ? {addr_reg[31:2], 2'b00} : 32'h0;
        dmem_wdata = waiting ? wdata_reg : 32'h0;
        dmem_be    = waiting ? be_reg : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg   <= 32'h0;
            funct3_reg <= 3'h0;
            we_reg     <= 1'b0;
            wdata_reg  <= 32'h0;
            be_reg     <= 4'h0;
            rd_reg     <= 5'h0;
            wb_sel_reg <= 3'h0;
            reg_we_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            if (start) begin
                addr_reg   <= addr_in;
                funct3_reg <= funct3_in;
                we_reg     <= mem_request_write_in;
                wdata_reg  <= al_wdata;
                be_reg     <= al_be;
                rd_reg     <= rd_in;
                wb_sel_reg <= wb_sel_in;
                reg_we_reg <= reg_we_in;
            end
            if (waiting && !dmem_ack && !timeout_hit) cnt_reg <= cnt_reg + 1'b1;
            else                                      cnt_reg <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_out <= 32'h0;
            mem_data_out   <= 32'h0;
            rd_out         <= 5'h0;
            reg_we_out     <= 1'b0;
            wb_sel_out     <= 3'h0;
            fault_out      <= 1'b0;
        end else if (!waiting) begin
            // Memory ops and faults leave a bubble; only plain ALU ops write back from here.
            alu_result_out <= addr_in;
            mem_data_out   <= 32'h0;
            rd_out         <= rd_in;
            reg_we_out     <= reg_we_in && !mem_request_type_in;
            wb_sel_out     <= wb_sel_in;
            fault_out      <= bad;
        end else if (dmem_ack || timeout_hit) begin
            alu_result_out <= addr_reg;
            mem_data_out   <= (dmem_ack && !we_reg) ? al_load : 32'h0;
            rd_out         <= rd_reg;
            reg_we_out     <= dmem_ack && reg_we_reg;
            wb_sel_out     <= wb_sel_reg;
            fault_out      <= !dmem_ack;
        end else begin
            reg_we_out <= 1'b0;
            fault_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset and
// ALU-op sequences, and random memory ops checked against a byte-level model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_in, store_data_in, dmem_rdata;
    logic [4:0]  rd_in;
    logic        reg_we_in, mem_request_type_in, mem_request_write_in, dmem_ack;
    logic [2:0]  wb_sel_in, funct3_in;
    logic        dmem_req, dmem_we, stall_out, reg_we_out, fault_out;
    logic [31:0] dmem_addr, dmem_wdata, alu_result_out, mem_data_out;
    logic [3:0]  dmem_be;
    logic [4:0]  rd_out;
    logic [2:0]  wb_sel_out;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .addr_in(addr_in), .store_data_in(store_data_in), .rd_in(rd_in),
        .reg_we_in(reg_we_in), .wb_sel_in(wb_sel_in),
        .mem_request_type_in(mem_request_type_in), .mem_request_write_in(mem_request_write_in),
        .funct3_in(funct3_in), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .stall_out(stall_out),
        .alu_result_out(alu_result_out), .mem_data_out(mem_data_out), .rd_out(rd_out),
        .reg_we_out(reg_we_out), .wb_sel_out(wb_sel_out), .fault_out(fault_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic        w;
        logic [31:0] sd;
        logic [31:0] rword;
        int          waits;
        logic        fault;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          nreq;
    } vec_t;

    typedef struct {
        logic        fault, fault_next, reg_we, dwe, stable, done, req_after;
        logic [31:0] data, data_next, alu, wdata, daddr;
        logic [4:0]  rdo;
        logic [3:0]  be;
        int          nreq, nstall;
    } obs_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: sizes, lane positions and extension from plain arithmetic.
    function automatic vec_t model(input logic [2:0] f3, input logic [31:0] a, input logic w,
                                   input logic [31:0] sd, input logic [31:0] rword, input int waits);
        vec_t r;
        int size, off;
        bit ok, tmo;
        logic [31:0] v, mask;
        size = 1 << f3[1:0];
        off  = int'(a[1:0]);
        ok   = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        ok   = ok && ((off % size) == 0);
        tmo  = ok && (waits >= 4);
        r.f3 = f3; r.a = a; r.w = w; r.sd = sd; r.rword = rword; r.waits = waits;
        r.be = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
        v = rword >> (8 * off);
        if (size < 4) begin
            mask = (32'h1 << (8 * size)) - 32'h1;
            v = v & mask;
            if (!f3[2] && v[8*size-1]) v = v | ~mask;
        end
        r.fault = !ok || tmo;
        r.nreq  = !ok ? 0 : (tmo ? 4 : waits + 1);
        r.data  = (ok && !tmo && !w) ? v : 32'h0;
        return r;
    endfunction

    task automatic run_mem(input vec_t v, input logic [4:0] rdv, output obs_t o);
        logic stall_now;
        o = '{default: 0};
        o.stable = 1'b1;
        addr_in = v.a; store_data_in = v.sd; rd_in = rdv; reg_we_in = !v.w; wb_sel_in = 3'd2;
        mem_request_type_in = 1'b1; mem_request_write_in = v.w; funct3_in = v.f3;
        dmem_rdata = v.rword; dmem_ack = 1'b0;
        for (int cyc = 0; cyc < 40 && !o.done; cyc++) begin
            #1;
            if (dmem_req) begin
                if (o.nreq == 0) begin
                    o.be = dmem_be; o.wdata = dmem_wdata; o.daddr = dmem_addr; o.dwe = dmem_we;
                end else if ({dmem_be, dmem_wdata, dmem_addr, dmem_we} !== {o.be, o.wdata, o.daddr, o.dwe}) begin
                    o.stable = 1'b0;
                end
                dmem_ack = (o.nreq == v.waits);
                o.nreq++;
            end else begin
                dmem_ack = 1'b0;
            end
            #1;
            stall_now = stall_out;
            if (stall_now) o.nstall++;
            @(posedge clk); #1;
            if (!stall_now) o.done = 1'b1;
        end
        dmem_ack = 1'b0; mem_request_type_in = 1'b0; reg_we_in = 1'b0;
        #1;
        o.fault = fault_out; o.data = mem_data_out; o.reg_we = reg_we_out;
        o.rdo = rd_out; o.alu = alu_result_out; o.req_after = dmem_req;
        @(posedge clk); #1;
        o.fault_next = fault_out; o.data_next = mem_data_out;
    endtask

    task automatic check_vec(input string p, input vec_t v, input logic [4:0] rdv, input obs_t o);
        chk({p, ".done"},       o.done, 1);
        chk({p, ".fault"},      o.fault, v.fault);
        chk({p, ".fault_once"}, o.fault_next, 0);
        chk({p, ".nreq"},       o.nreq, v.nreq);
        chk({p, ".nstall"},     o.nstall, v.nreq);
        chk({p, ".req_after"},  o.req_after, 0);
        chk({p, ".data"},       o.data, v.data);
        chk({p, ".data_clear"}, o.data_next, 0);
        chk({p, ".reg_we"},     o.reg_we, (v.fault || v.w) ? 0 : 1);
        chk({p, ".rd"},         o.rdo, rdv);
        chk({p, ".alu"},        o.alu, v.a);
        if (v.nreq > 0) begin
            chk({p, ".be"},     o.be, v.be);
            chk({p, ".daddr"},  o.daddr, {v.a[31:2], 2'b00});
            chk({p, ".we"},     o.dwe, v.w);
            chk({p, ".stable"}, o.stable, 1);
            if (v.w) chk({p, ".wdata"}, o.wdata, v.wdata);
        end
        $display("%s f3=%0d addr=0x%08h we=%0b waits=%0d -> fault=%0b data=0x%08h nreq=%0d",
                 p, v.f3, v.a, v.w, v.waits, o.fault, o.data, o.nreq);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[14];
        vec_t v;
        obs_t o;

        tbl[0]  = '{3'd0, 32'h103, 1'b1, 32'hAABBCCDD, 32'h0,        2,  1'b0, 32'h0,        4'b1000, 32'hDDDDDDDD, 3};
        tbl[1]  = '{3'd0, 32'h102, 1'b0, 32'h0,        32'h00800000, 0,  1'b0, 32'hFFFFFF80, 4'b0100, 32'h0,        1};
        tbl[2]  = '{3'd4, 32'h102, 1'b0, 32'h0,        32'h00800000, 1,  1'b0, 32'h00000080, 4'b0100, 32'h0,        2};
        tbl[3]  = '{3'd1, 32'h102, 1'b0, 32'h0,        32'h80011234, 0,  1'b0, 32'hFFFF8001, 4'b1100, 32'h0,        1};
        tbl[4]  = '{3'd2, 32'h101, 1'b0, 32'h0,        32'hDEADBEEF, 0,  1'b1, 32'h0,        4'b0000, 32'h0,        0};
        tbl[5]  = '{3'd1, 32'h102, 1'b1, 32'h12345678, 32'h0,        0,  1'b0, 32'h0,        4'b1100, 32'h56785678, 1};
        tbl[6]  = '{3'd2, 32'h100, 1'b1, 32'hCAFEBABE, 32'h0,        0,  1'b0, 32'h0,        4'b1111, 32'hCAFEBABE, 1};
        tbl[7]  = '{3'd5, 32'h100, 1'b0, 32'h0,        32'h1234F00D, 2,  1'b0, 32'h0000F00D, 4'b0011, 32'h0,        3};
        tbl[8]  = '{3'd2, 32'h104, 1'b0, 32'h0,        32'hDEADBEEF, 3,  1'b0, 32'hDEADBEEF, 4'b1111, 32'h0,        4};
        tbl[9]  = '{3'd2, 32'h108, 1'b0, 32'h0,        32'h11111111, 99, 1'b1, 32'h0,        4'b1111, 32'h0,        4};
        tbl[10] = '{3'd3, 32'h100, 1'b0, 32'h0,        32'h22222222, 0,  1'b1, 32'h0,        4'b0000, 32'h0,        0};
        tbl[11] = '{3'd4, 32'h100, 1'b1, 32'h55,       32'h0,        0,  1'b1, 32'h0,        4'b0000, 32'h0,        0};
        tbl[12] = '{3'd1, 32'h103, 1'b1, 32'h1234,     32'h0,        0,  1'b1, 32'h0,        4'b0000, 32'h0,        0};
        tbl[13] = '{3'd0, 32'h101, 1'b0, 32'h0,        32'h00007F00, 1,  1'b0, 32'h0000007F, 4'b0010, 32'h0,        2};

        // Reset with a legal request presented: everything must read zero.
        rst = 1'b1;
        addr_in = 32'h100; store_data_in = 32'h0; rd_in = 5'd1; reg_we_in = 1'b1; wb_sel_in = 3'd1;
        mem_request_type_in = 1'b1; mem_request_write_in = 1'b0; funct3_in = 3'd2;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.stall", stall_out, 0);
        chk("reset.req", dmem_req, 0);
        chk("reset.outs", {alu_result_out ^ mem_data_out, 27'h0, rd_out}, 0);
        chk("reset.flags", {reg_we_out, wb_sel_out, fault_out}, 0);
        mem_request_type_in = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Plain ALU op, with a stray ack that IDLE must ignore.
        addr_in = 32'h1234; rd_in = 5'd5; reg_we_in = 1'b1; wb_sel_in = 3'd1; dmem_ack = 1'b1;
        #1;
        chk("alu_op.stall", stall_out, 0);
        chk("alu_op.req", dmem_req, 0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("alu_op.alu", alu_result_out, 32'h1234);
        chk("alu_op.rd", rd_out, 5);
        chk("alu_op.reg_we", reg_we_out, 1);
        chk("alu_op.wb_sel", wb_sel_out, 1);
        chk("alu_op.data", mem_data_out, 0);
        chk("alu_op.fault", fault_out, 0);
        chk("alu_op.req_after", dmem_req, 0);
        $display("alu_op addr=0x%08h -> alu_result=0x%08h rd=%0d reg_we=%0b",
                 addr_in, alu_result_out, rd_out, reg_we_out);

        for (int i = 0; i < 14; i++) begin
            run_mem(tbl[i], 5'(i + 3), o);
            check_vec($sformatf("vec%0d", i), tbl[i], 5'(i + 3), o);
        end

        // Reset while a load is outstanding.
        addr_in = 32'h200; rd_in = 5'd9; reg_we_in = 1'b1; wb_sel_in = 3'd2;
        mem_request_type_in = 1'b1; mem_request_write_in = 1'b0; funct3_in = 3'd2;
        dmem_rdata = 32'h0BADF00D;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_mid.req_before", dmem_req, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid.req", dmem_req, 0);
        chk("rst_mid.stall", stall_out, 0);
        chk("rst_mid.bus", {dmem_addr | dmem_wdata, 27'h0, dmem_be, dmem_we}, 0);
        chk("rst_mid.alu", alu_result_out, 0);
        chk("rst_mid.flags", {rd_out, reg_we_out, wb_sel_out, fault_out}, 0);
        mem_request_type_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid.no_fault", fault_out, 0);
        $display("rst_mid addr=0x200 -> req=%0b fault=%0b after reset", dmem_req, fault_out);
        v = model(3'd2, 32'h200, 1'b0, 32'h0, 32'h0BADF00D, 0);
        run_mem(v, 5'd9, o);
        check_vec("after_rst", v, 5'd9, o);

        for (int i = 0; i < 60; i++) begin
            logic [4:0] rdv;
            rdv = 5'($urandom_range(0, 31));
            v = model(3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
                      $urandom, $urandom, $urandom_range(0, 5));
            run_mem(v, rdv, o);
            check_vec($sformatf("rnd%0d", i), v, rdv, o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
